// File: rtl/spi_xfer_ctrl.sv
// Transaction sequencer in front of a byte-level SPI master engine: owns slave select,
// CS setup/hold/gap timing, and streams bytes between the host and the engine.
module spi_xfer_ctrl #(
  parameter int NUM_SS   = 4,
  parameter int SS_W     = 2,
  parameter int LEN_W    = 4,
  parameter int CS_SETUP = 4,
  parameter int CS_HOLD  = 4,
  parameter int CS_GAP   = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [SS_W-1:0]   cmd_ss,
  input  logic              wr_valid,
  input  logic [7:0]        wr_data,
  output logic              wr_ready,
  output logic              rd_valid,
  output logic [7:0]        rd_data,
  output logic              busy,
  output logic              spi_start,
  output logic [7:0]        spi_tx_data,
  input  logic [7:0]        spi_rx_data,
  input  logic              spi_tx_ready,
  input  logic              spi_done,
  output logic [NUM_SS-1:0] ss_n
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    LOAD  = 3'd2,
    XFER  = 3'd3,
    HOLD  = 3'd4,
    GAP   = 3'd5
  } state_t;

  localparam logic [7:0] SETUP_LAST = 8'(CS_SETUP - 1);
  localparam logic [7:0] HOLD_LAST  = 8'(CS_HOLD - 1);
  localparam logic [7:0] GAP_LAST   = 8'(CS_GAP - 1);

  state_t             state;
  state_t             state_next;
  logic [7:0]         dly_cnt;
  logic [LEN_W-1:0]   byte_cnt;
  logic [NUM_SS-1:0]  ss_decode;
  logic               accept;
  logic               xfer_done;
  logic               last_byte;

  assign spi_tx_data = wr_data;
  assign busy        = (state != IDLE);
  assign accept      = (state == IDLE) && cmd_valid;
  assign xfer_done   = (state == XFER) && spi_done;
  assign last_byte   = (byte_cnt == '0);

  // An out-of-range slave index matches no line, so the frame runs with every select high.
  always_comb begin
    ss_decode = '1;
    for (int i = 0; i < NUM_SS; i++) begin
      ss_decode[i] = (cmd_ss != SS_W'(i));
    end
  end

  always_comb begin
    state_next = state;
    cmd_ready  = 1'b0;
    wr_ready   = 1'b0;
    spi_start  = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_next = SETUP;
      end
      SETUP: begin
        if (dly_cnt == SETUP_LAST) state_next = LOAD;
      end
      LOAD: begin
        wr_ready  = spi_tx_ready;
        spi_start = wr_valid && spi_tx_ready;
        if (wr_valid && spi_tx_ready) state_next = XFER;
      end
      XFER: begin
        if (spi_done) state_next = last_byte ? HOLD : LOAD;
      end
      HOLD: begin
        if (dly_cnt == HOLD_LAST) state_next = GAP;
      end
      GAP: begin
        if (dly_cnt == GAP_LAST) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // The delay counter restarts from zero on every state change and only runs in timed states.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      dly_cnt <= '0;
    end else begin
      state <= state_next;
      if (state_next != state) begin
        dly_cnt <= '0;
      end else if (state == SETUP || state == HOLD || state == GAP) begin
        dly_cnt <= dly_cnt + 8'd1;
      end else begin
        dly_cnt <= '0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      byte_cnt <= '0;
    end else if (accept) begin
      byte_cnt <= cmd_len;
    end else if (xfer_done && !last_byte) begin
      byte_cnt <= byte_cnt - 1'b1;
    end
  end

  // Selects drop the cycle after acceptance and rise only once the hold time has elapsed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ss_n <= '1;
    end else if (accept) begin
      ss_n <= ss_decode;
    end else if (state == HOLD && dly_cnt == HOLD_LAST) begin
      ss_n <= '1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= xfer_done;
      if (xfer_done) rd_data <= spi_rx_data;
    end
  end

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Directed bench for spi_xfer_ctrl with a loopback engine model (rx byte = tx byte)
// and a second instance using three slave selects for the out-of-range index case.
module tb_spi_xfer_ctrl;

  localparam int CS_SETUP = 4;
  localparam int CS_HOLD  = 4;
  localparam int CS_GAP   = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_valid2 = 1'b0;
  logic [3:0] cmd_len = '0;
  logic [1:0] cmd_ss = '0;
  logic       wr_valid = 1'b0;
  logic [7:0] wr_data = '0;

  logic       cmd_ready, wr_ready, rd_valid, busy, spi_start;
  logic [7:0] rd_data, spi_tx_data;
  logic [3:0] ss_n;
  logic       cmd_ready2, wr_ready2, rd_valid2, busy2, spi_start2;
  logic [7:0] rd_data2, spi_tx_data2;
  logic [2:0] ss_n2;

  logic       e1_busy, e1_done, e2_busy, e2_done;
  logic [1:0] e1_cnt, e2_cnt;
  logic [7:0] e1_byte, e1_rx, e2_byte, e2_rx;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int start_cnt = 0;
  int done_cyc = 0;
  int rd_cyc = 0;
  int rd2_cnt = 0;
  logic [7:0] rd2_last = '0;
  logic [7:0] rd_q[$];
  logic       watch1 = 1'b0;
  logic [3:0] watch_ss = '1;
  int ss1_err = 0;
  int ss2_err = 0;
  logic       b2b_watch = 1'b0;
  int cr_cnt = 0;
  int t_acc = 0;
  int load_cyc = 0;
  int d, r0, s0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  spi_xfer_ctrl #(.NUM_SS(4), .SS_W(2), .LEN_W(4),
                  .CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD), .CS_GAP(CS_GAP)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len), .cmd_ss(cmd_ss),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
    .rd_valid(rd_valid), .rd_data(rd_data), .busy(busy),
    .spi_start(spi_start), .spi_tx_data(spi_tx_data), .spi_rx_data(e1_rx),
    .spi_tx_ready(!e1_busy), .spi_done(e1_done), .ss_n(ss_n)
  );

  spi_xfer_ctrl #(.NUM_SS(3), .SS_W(2), .LEN_W(4),
                  .CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD), .CS_GAP(CS_GAP)) dut2 (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid2), .cmd_ready(cmd_ready2), .cmd_len(cmd_len), .cmd_ss(cmd_ss),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready2),
    .rd_valid(rd_valid2), .rd_data(rd_data2), .busy(busy2),
    .spi_start(spi_start2), .spi_tx_data(spi_tx_data2), .spi_rx_data(e2_rx),
    .spi_tx_ready(!e2_busy), .spi_done(e2_done), .ss_n(ss_n2)
  );

  // Loopback engine models: a start launches a 4-cycle byte, then done pulses with rx = tx.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      e1_busy <= 1'b0; e1_cnt <= '0; e1_byte <= '0; e1_done <= 1'b0; e1_rx <= '0;
    end else begin
      e1_done <= 1'b0;
      if (e1_busy) begin
        if (e1_cnt == 2'd0) begin
          e1_busy <= 1'b0; e1_done <= 1'b1; e1_rx <= e1_byte;
        end else begin
          e1_cnt <= e1_cnt - 2'd1;
        end
      end else if (spi_start) begin
        e1_busy <= 1'b1; e1_cnt <= 2'd3; e1_byte <= spi_tx_data;
      end
    end
  end

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      e2_busy <= 1'b0; e2_cnt <= '0; e2_byte <= '0; e2_done <= 1'b0; e2_rx <= '0;
    end else begin
      e2_done <= 1'b0;
      if (e2_busy) begin
        if (e2_cnt == 2'd0) begin
          e2_busy <= 1'b0; e2_done <= 1'b1; e2_rx <= e2_byte;
        end else begin
          e2_cnt <= e2_cnt - 2'd1;
        end
      end else if (spi_start2) begin
        e2_busy <= 1'b1; e2_cnt <= 2'd3; e2_byte <= spi_tx_data2;
      end
    end
  end

  always @(negedge clk) begin
    if (rd_valid) begin
      rd_q.push_back(rd_data);
      rd_cyc = cyc;
    end
    if (rd_valid2) begin
      rd2_cnt++;
      rd2_last = rd_data2;
    end
    if (spi_start) start_cnt++;
    if (e1_done) done_cyc = cyc;
    if (watch1 && ss_n !== watch_ss) ss1_err++;
    if (ss_n2 !== 3'b111) ss2_err++;
    if (b2b_watch && cmd_ready) cr_cnt++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected)
      else begin
        bad++;
        $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] len, input logic [1:0] ss, input bit which, input string tag);
    cmd_len = len;
    cmd_ss  = ss;
    if (which) cmd_valid2 = 1'b1;
    else       cmd_valid  = 1'b1;
    #1;
    checkOutput(tag, 32'(which ? cmd_ready2 : cmd_ready), 32'd1);
    t_acc = cyc;
    step();
    cmd_valid  = 1'b0;
    cmd_valid2 = 1'b0;
  endtask

  task automatic pushByte(input logic [7:0] b, input bit which, input string tag);
    int n = 0;
    wr_data  = b;
    wr_valid = 1'b1;
    #1;
    while (!(which ? spi_start2 : spi_start) && n < 300) begin
      step();
      n++;
    end
    checkOutput(tag, 32'(which ? spi_start2 : spi_start), 32'd1);
    load_cyc = cyc;
    step();
    wr_valid = 1'b0;
  endtask

  task automatic waitRd(input int target, input bit which, input string tag);
    int n = 0;
    while ((which ? rd2_cnt : rd_q.size()) < target && n < 300) begin
      step();
      n++;
    end
    checkOutput(tag, 32'(which ? rd2_cnt : rd_q.size()), 32'(target));
  endtask

  task automatic waitIdle(input bit which, input string tag);
    int n = 0;
    while (!(which ? cmd_ready2 : cmd_ready) && n < 300) begin
      step();
      n++;
    end
    checkOutput(tag, 32'(which ? cmd_ready2 : cmd_ready), 32'd1);
  endtask

  task automatic waitCycle(input int c);
    int n = 0;
    while (cyc < c && n < 1000) begin
      step();
      n++;
    end
  endtask

  initial begin
    repeat (3) step();
    reset = 1'b0;
    step();
    checkOutput("rst_ss_n", 32'(ss_n), 32'hF);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    checkOutput("rst_rd_valid", 32'(rd_valid), 32'd0);
    checkOutput("rst_rd_data", 32'(rd_data), 32'd0);
    checkOutput("rst_spi_start", 32'(spi_start), 32'd0);
    checkOutput("rst_wr_ready", 32'(wr_ready), 32'd0);
    checkOutput("rst_ss_n2", 32'(ss_n2), 32'h7);

    // single byte to slave 2
    s0 = start_cnt;
    applyStimulus(4'd0, 2'd2, 1'b0, "t1_accept");
    checkOutput("t1_ss_n", 32'(ss_n), 32'b1011);
    checkOutput("t1_busy", 32'(busy), 32'd1);
    checkOutput("t1_cmd_ready_low", 32'(cmd_ready), 32'd0);
    pushByte(8'hA5, 1'b0, "t1_start");
    checkOutput("t1_setup_delay", 32'(load_cyc - t_acc), 32'(CS_SETUP + 1));
    waitRd(1, 1'b0, "t1_rd_count");
    checkOutput("t1_rd_data", 32'(rd_q[0]), 32'hA5);
    checkOutput("t1_rd_after_done", 32'(rd_cyc - done_cyc), 32'd1);
    d = done_cyc;
    waitCycle(d + CS_HOLD);
    checkOutput("t1_ss_hold", 32'(ss_n), 32'b1011);
    step();
    checkOutput("t1_ss_release", 32'(ss_n), 32'hF);
    checkOutput("t1_gap_busy", 32'(busy), 32'd1);
    waitIdle(1'b0, "t1_idle");
    checkOutput("t1_gap_len", 32'(cyc - d), 32'(CS_HOLD + CS_GAP + 1));
    checkOutput("t1_one_rd", 32'(rd_q.size()), 32'd1);
    checkOutput("t1_one_start", 32'(start_cnt - s0), 32'd1);

    // three bytes to slave 0, select held across the frame
    s0 = start_cnt;
    r0 = rd_q.size();
    applyStimulus(4'd2, 2'd0, 1'b0, "t2_accept");
    watch_ss = 4'b1110;
    watch1 = 1'b1;
    pushByte(8'h01, 1'b0, "t2_start0");
    pushByte(8'h80, 1'b0, "t2_start1");
    pushByte(8'hFF, 1'b0, "t2_start2");
    waitRd(r0 + 3, 1'b0, "t2_rd_count");
    watch1 = 1'b0;
    checkOutput("t2_rd0", 32'(rd_q[r0]), 32'h01);
    checkOutput("t2_rd1", 32'(rd_q[r0+1]), 32'h80);
    checkOutput("t2_rd2", 32'(rd_q[r0+2]), 32'hFF);
    checkOutput("t2_starts", 32'(start_cnt - s0), 32'd3);
    checkOutput("t2_ss_continuous", 32'(ss1_err), 32'd0);
    waitIdle(1'b0, "t2_idle");
    checkOutput("t2_rd_total", 32'(rd_q.size()), 32'(r0 + 3));

    // write underflow on the second byte
    s0 = start_cnt;
    r0 = rd_q.size();
    applyStimulus(4'd1, 2'd1, 1'b0, "t3_accept");
    watch_ss = 4'b1101;
    watch1 = 1'b1;
    pushByte(8'h3C, 1'b0, "t3_start0");
    waitRd(r0 + 1, 1'b0, "t3_rd_first");
    repeat (100) step();
    checkOutput("t3_no_start", 32'(start_cnt - s0), 32'd1);
    checkOutput("t3_no_rd", 32'(rd_q.size()), 32'(r0 + 1));
    checkOutput("t3_wr_ready", 32'(wr_ready), 32'd1);
    checkOutput("t3_busy", 32'(busy), 32'd1);
    checkOutput("t3_ss_held", 32'(ss_n), 32'b1101);
    pushByte(8'hC3, 1'b0, "t3_start1");
    waitRd(r0 + 2, 1'b0, "t3_rd_second");
    watch1 = 1'b0;
    checkOutput("t3_rd0", 32'(rd_q[r0]), 32'h3C);
    checkOutput("t3_rd1", 32'(rd_q[r0+1]), 32'hC3);
    checkOutput("t3_ss_err", 32'(ss1_err), 32'd0);
    waitIdle(1'b0, "t3_idle");

    // back-to-back with cmd_valid held high
    r0 = rd_q.size();
    cmd_len = 4'd0;
    cmd_ss = 2'd3;
    cmd_valid = 1'b1;
    #1;
    checkOutput("t4_accept1", 32'(cmd_ready), 32'd1);
    step();
    b2b_watch = 1'b1;
    cr_cnt = 0;
    checkOutput("t4_ss_first", 32'(ss_n), 32'b0111);
    pushByte(8'h77, 1'b0, "t4_start0");
    waitRd(r0 + 1, 1'b0, "t4_rd_first");
    d = done_cyc;
    waitIdle(1'b0, "t4_accept2");
    checkOutput("t4_gap", 32'(cyc - d), 32'(CS_HOLD + CS_GAP + 1));
    checkOutput("t4_cr_once", 32'(cr_cnt), 32'd1);
    checkOutput("t4_ss_gap", 32'(ss_n), 32'hF);
    step();
    cmd_valid = 1'b0;
    b2b_watch = 1'b0;
    checkOutput("t4_ss_second", 32'(ss_n), 32'b0111);
    pushByte(8'h88, 1'b0, "t4_start1");
    waitRd(r0 + 2, 1'b0, "t4_rd_second");
    checkOutput("t4_rd1", 32'(rd_q[r0+1]), 32'h88);
    waitIdle(1'b0, "t4_idle");

    // reset while the second of four bytes is in flight
    r0 = rd_q.size();
    applyStimulus(4'd3, 2'd2, 1'b0, "t5_accept");
    pushByte(8'h11, 1'b0, "t5_start0");
    waitRd(r0 + 1, 1'b0, "t5_rd_first");
    pushByte(8'h22, 1'b0, "t5_start1");
    checkOutput("t5_in_xfer_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    checkOutput("t5_ss_async", 32'(ss_n), 32'hF);
    checkOutput("t5_busy_rst", 32'(busy), 32'd0);
    step();
    step();
    reset = 1'b0;
    step();
    checkOutput("t5_cmd_ready", 32'(cmd_ready), 32'd1);
    checkOutput("t5_busy", 32'(busy), 32'd0);
    checkOutput("t5_rd_data_clr", 32'(rd_data), 32'd0);
    repeat (20) step();
    checkOutput("t5_no_rd", 32'(rd_q.size()), 32'(r0 + 1));

    // out-of-range slave index on the three-select instance
    applyStimulus(4'd0, 2'd3, 1'b1, "t6_accept");
    checkOutput("t6_busy2", 32'(busy2), 32'd1);
    pushByte(8'h5A, 1'b1, "t6_start");
    waitRd(1, 1'b1, "t6_rd_count");
    checkOutput("t6_rd_data", 32'(rd2_last), 32'h5A);
    waitIdle(1'b1, "t6_idle2");
    checkOutput("t6_ss_never", 32'(ss2_err), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
